cordic_gain_comp: RTL
=====================

Name: cordic_gain_comp

Overview:
Downstream neighbour of the final CORDIC rotation micro-stage. Takes the un-normalised x/y pair plus its valid and removes the CORDIC gain by multiplying both by K ≈ 0.6072529. The multiply is a 2-stage shift-add (CSD) pipeline with no multipliers. Results are buffered in a small FIFO with a valid/ready output handshake and a credit-based `in_ready`, which upstream uses to drive its enable.

Parameters:
- CORDIC_WIDTH, 22, data width of x/y in and out (signed, two's complement)
- GUARD_BITS, 4, extra LSBs carried through the shift-add before the final reduction
- FIFO_DEPTH, 4, output buffer entries; must be ≥ 3 (pipeline depth + 1)

Ports:
- clk, input, 1, clock
- reset, input, 1, synchronous, active-high reset
- x_in, input, CORDIC_WIDTH, signed x from last rotation stage
- y_in, input, CORDIC_WIDTH, signed y from last rotation stage
- in_valid, input, 1, x_in/y_in valid (driven by upstream op_valid)
- in_ready, output, 1, space guaranteed for one more sample
- x_out, output, CORDIC_WIDTH, gain-compensated x at FIFO head
- y_out, output, CORDIC_WIDTH, gain-compensated y at FIFO head
- out_valid, output, 1, FIFO non-empty
- out_ready, input, 1, consumer accepts head this cycle
- level, output, $clog2(FIFO_DEPTH+1), FIFO occupancy
- drop_err, output, 1, sticky: a sample arrived while in_ready=0
- err_clr, input, 1, clears drop_err

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset sampled on rising clk).
  - Reset clears pipeline valids, FIFO pointers and count, and drop_err.
  - Outputs after reset: out_valid=0, level=0, drop_err=0, in_ready=1, x_out/y_out=0.
  - Reset mid-operation discards all in-flight and buffered samples, with no partial output.
- Gain constant: K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16 = 0.607254028 (error ≈ 1.1e-6).
- Arithmetic:
  - Internal width is CORDIC_WIDTH + GUARD_BITS + 1.
  - The operand is sign-extended, then left-shifted by GUARD_BITS.
  - Every term is an arithmetic right shift (floor), sign preserved.
  - x and y use identical, independent datapaths.
- Pipeline stages:
  - S1 (edge k, when in_valid=1 and in_ready=1): registers p1 = t1 + t3 - t6 - t9 and p2 = -t12 + t14 + t16 for x and y, plus s1_v.
  - S2 (edge k+1): registers sum = p1 + p2, reduced to CORDIC_WIDTH by dropping GUARD_BITS (see Optional Feature), plus s2_v.
  - FIFO write happens on edge k+2 when s2_v=1. The FIFO is first-word-fall-through, so out_valid rises after edge k+2.
  - Minimum latency: 3 edges from the accepting edge to out_valid.
- Overflow: |K| < 1, so no overflow is possible. No saturation logic is required.
- in_ready (combinational from registers only) = (count + s1_v + s2_v) < FIFO_DEPTH.
- Pipeline hazards: a pipeline write can never hit a full FIFO. If in_valid=1 and in_ready=0, the sample is discarded, drop_err is set the next edge, and no state other than drop_err changes.
- FIFO:
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
  - Pop when empty and push when full are impossible by construction; assert on them in simulation.
  - x_out/y_out hold the head value while out_valid=1 && out_ready=0. They are don't-care when empty but must not be X after reset.
- drop_err and err_clr: a drop_err set-event on the same edge as err_clr wins (flag stays 1).

Optional Feature:
- Macro: CORDIC_GAIN_ROUND_EN.
- Defined: round-half-up. Add 2^(GUARD_BITS-1) to the internal sum, then arithmetic shift right by GUARD_BITS.
- Undefined: plain arithmetic shift right (floor), matching the truncating convention of the rotation stages.
- Latency and interface are identical in both builds.

Decomposition:
- Shared package `cordic_pkg` holds:
  - the CSD shift list and signs (localparam arrays)
  - K as a real, for bench reference
  - the default width and guard constants
- One sub-module is natural: `cordic_gain_fifo`, the parameterised FWFT FIFO exposing count, push, pop and head. It is reusable for other CORDIC output buffers.
- The shift-add datapath stays inline, instantiated twice as generate blocks (x, y).

Test Plan:
1. Gain and latency: reset, then x_in=1048576, y_in=-1048576 with in_valid for one cycle → after 3 edges out_valid=1, x_out=636752, y_out=-636752 (both builds).
2. Rounding: x_in=1, y_in=-1 → x_out=0 (floor) / 1 (ROUND_EN); y_out=-1 in both builds.
3. Backpressure: out_ready=0 with a continuous in_valid stream → in_ready drops after 4 accepts, level=4, no drop. Raising out_ready drains the samples in order with values intact.
4. Drop: hold in_valid=1 while in_ready=0 → drop_err=1 next edge, level unchanged. err_clr pulse clears it. err_clr coincident with a new drop keeps it at 1.
5. Throughput: with out_ready=1, 100 back-to-back random samples → one output per cycle, all within 1 LSB of round(v·0.6072529). level never exceeds 1 in steady state.
6. Reset mid-stream: assert reset with 2 samples in flight and 2 buffered → next cycle out_valid=0, level=0, in_ready=1, and nothing stale emerges afterward.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC output path: default sizes, the CSD
// decomposition of the gain-compensation constant K, and K as a real.
package cordic_pkg;

  localparam int CORDIC_WIDTH_DEF = 22;
  localparam int GUARD_BITS_DEF   = 4;
  localparam int FIFO_DEPTH_DEF   = 4;

  // K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16; the first
  // CSD_P1_TERMS terms form partial sum p1, the remainder form p2.
  localparam int CSD_TERMS    = 7;
  localparam int CSD_P1_TERMS = 4;
  localparam int CSD_SHIFT [CSD_TERMS] = '{1, 3, 6, 9, 12, 14, 16};
  localparam bit CSD_NEG   [CSD_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  localparam real CORDIC_K = 0.607254028;

endpackage

// File: rtl/cordic_gain_fifo.sv
// First-word-fall-through FIFO used as a CORDIC output buffer; exposes
// occupancy so the producer can run credit-based flow control.
module cordic_gain_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared on reset so the head never reads as X when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (pop_i) rdPtr_q <= nextPtr(rdPtr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  pushWhenFull: assert property (@(posedge clk) disable iff (reset)
    !(push_i && (count_q == CW'(DEPTH))));
  popWhenEmpty: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && (count_q == '0)));

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: x/y times K via a 2-stage CSD shift-add, buffered
// in a FWFT FIFO. Define CORDIC_GAIN_ROUND_EN for round-half-up reduction.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
  parameter int GUARD_BITS   = GUARD_BITS_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [CORDIC_WIDTH-1:0]    x_in,
  input  logic signed [CORDIC_WIDTH-1:0]    y_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic signed [CORDIC_WIDTH-1:0]    x_out,
  output logic signed [CORDIC_WIDTH-1:0]    y_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              drop_err,
  input  logic                              err_clr
);

  localparam int IW = CORDIC_WIDTH + GUARD_BITS + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [IW-1:0] HALF_LSB = IW'(1) << (GUARD_BITS - 1);
`else
  localparam logic signed [IW-1:0] HALF_LSB = '0;
`endif

  logic                           acceptIn;
  logic                           s1Valid_q;
  logic                           s2Valid_q;
  logic                           dropErr_q;
  logic                           dropErr_d;
  logic [CW-1:0]                  fifoCount;
  logic [2*CORDIC_WIDTH-1:0]      fifoHead;
  logic signed [CORDIC_WIDTH-1:0] chanIn  [2];
  logic signed [CORDIC_WIDTH-1:0] chanOut [2];

  // Credits count samples already in the pipeline, so a write never meets a full FIFO.
  assign in_ready  = (int'(fifoCount) + int'(s1Valid_q) + int'(s2Valid_q)) < FIFO_DEPTH;
  assign acceptIn  = in_valid && in_ready;
  assign dropErr_d = (dropErr_q && !err_clr) || (in_valid && !in_ready);

  assign chanIn[0] = x_in;
  assign chanIn[1] = y_in;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic signed [IW-1:0]           ext;
    logic signed [IW-1:0]           p1_d;
    logic signed [IW-1:0]           p2_d;
    logic signed [IW-1:0]           p1_q;
    logic signed [IW-1:0]           p2_q;
    logic signed [IW-1:0]           sum_d;
    logic signed [CORDIC_WIDTH-1:0] red_d;
    logic signed [CORDIC_WIDTH-1:0] red_q;

    assign ext = IW'(chanIn[ch]) <<< GUARD_BITS;

    always_comb begin
      p1_d = '0;
      p2_d = '0;
      for (int i = 0; i < CSD_TERMS; i++) begin
        if (i < CSD_P1_TERMS)
          p1_d = CSD_NEG[i] ? p1_d - (ext >>> CSD_SHIFT[i]) : p1_d + (ext >>> CSD_SHIFT[i]);
        else
          p2_d = CSD_NEG[i] ? p2_d - (ext >>> CSD_SHIFT[i]) : p2_d + (ext >>> CSD_SHIFT[i]);
      end
    end

    assign sum_d = p1_q + p2_q + HALF_LSB;
    assign red_d = CORDIC_WIDTH'(sum_d >>> GUARD_BITS);

    always_ff @(posedge clk) begin
      if (acceptIn) begin
        p1_q <= p1_d;
        p2_q <= p2_d;
      end
      if (s1Valid_q) red_q <= red_d;
    end

    assign chanOut[ch] = red_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      dropErr_q <= 1'b0;
    end else begin
      s1Valid_q <= acceptIn;
      s2Valid_q <= s1Valid_q;
      dropErr_q <= dropErr_d;
    end
  end

  cordic_gain_fifo #(
    .WIDTH (2 * CORDIC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s2Valid_q),
    .data_i  ({chanOut[0], chanOut[1]}),
    .pop_i   (out_valid && out_ready),
    .data_o  (fifoHead),
    .count_o (fifoCount)
  );

  assign x_out     = fifoHead[2*CORDIC_WIDTH-1:CORDIC_WIDTH];
  assign y_out     = fifoHead[CORDIC_WIDTH-1:0];
  assign out_valid = (fifoCount != '0);
  assign level     = fifoCount;
  assign drop_err  = dropErr_q;

endmodule
